// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC / branch unit: branch funct3 encodings,
// FSM state encoding and the default reset PC.
package pc_branch_unit_pkg;

   localparam logic [31:0] DefaultResetPc = 32'h0100_0000;

   localparam logic [2:0] F3Beq  = 3'b000;
   localparam logic [2:0] F3Bne  = 3'b001;
   localparam logic [2:0] F3Blt  = 3'b100;
   localparam logic [2:0] F3Bge  = 3'b101;
   localparam logic [2:0] F3Bltu = 3'b110;
   localparam logic [2:0] F3Bgeu = 3'b111;

   // Number of unstalled cycles spent squashing IF/ID after a redirect.
   localparam logic [1:0] FlushCycles = 2'd2;

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StFlush = 2'd1,
      StHalt  = 2'd2
   } pcState_t;

endpackage

// File: rtl/branch_decide.sv
// Combinational branch decision and target generation for the EX-stage op.
module branch_decide
   import pc_branch_unit_pkg::*;
(
   input  logic        isBranch,
   input  logic        isJal,
   input  logic        isJalr,
   input  logic [2:0]  funct3,
   input  logic [31:0] exPc,
   input  logic [31:0] imm,
   input  logic [31:0] rs1,
   input  logic        brEq,
   input  logic        brLt,
   output logic        brUn,
   output logic        branchTaken,
   output logic        redirectReq,
   output logic [31:0] target
);

   logic        condMet;
   logic [31:0] sum;

   always_comb begin
      brUn = isBranch && ((funct3 == F3Bltu) || (funct3 == F3Bgeu));

      condMet = 1'b0;
      case (funct3)
         F3Beq:          condMet = brEq;
         F3Bne:          condMet = !brEq;
         F3Blt, F3Bltu:  condMet = brLt;
         F3Bge, F3Bgeu:  condMet = !brLt;
         default:        condMet = 1'b0;
      endcase

      branchTaken = isBranch && condMet;
      redirectReq = isJal || isJalr || branchTaken;

      sum    = (isJalr ? rs1 : exPc) + imm;
      target = isJalr ? {sum[31:1], 1'b0} : sum;
   end

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch PC register, redirect/flush/halt FSM and branch statistics counters.
module pc_branch_unit
   import pc_branch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DefaultResetPc,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic              stall,
   input  logic              ex_is_branch,
   input  logic              ex_is_jal,
   input  logic              ex_is_jalr,
   input  logic [2:0]        ex_funct3,
   input  logic [31:0]       ex_pc,
   input  logic [31:0]       ex_imm,
   input  logic [31:0]       ex_rs1,
   input  logic              BrEq,
   input  logic              BrLT,
   output logic              BrUn,
   output logic [31:0]       pc,
   output logic              flush,
   output logic              halted,
   output logic              misalign_err,
   output logic [CNT_W-1:0]  taken_cnt,
   output logic [CNT_W-1:0]  branch_cnt
);

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   pcState_t         stateQ, stateD;
   logic [31:0]      pcQ, pcD;
   logic [1:0]       flushCntQ, flushCntD;
   logic             misalignQ, misalignD;
   logic [CNT_W-1:0] takenCntQ, takenCntD;
   logic [CNT_W-1:0] branchCntQ, branchCntD;

   logic        branchTaken;
   logic        redirectReq;
   logic [31:0] target;
   logic        accept;
   logic        redirect;

   branch_decide u_decide (
      .isBranch    (ex_is_branch),
      .isJal       (ex_is_jal),
      .isJalr      (ex_is_jalr),
      .funct3      (ex_funct3),
      .exPc        (ex_pc),
      .imm         (ex_imm),
      .rs1         (ex_rs1),
      .brEq        (BrEq),
      .brLt        (BrLT),
      .brUn        (BrUn),
      .branchTaken (branchTaken),
      .redirectReq (redirectReq),
      .target      (target)
   );

   // Only RUN accepts EX ops; stall never blocks an accepted op.
   assign accept   = ex_valid && (stateQ == StRun);
   assign redirect = accept && redirectReq;

   always_comb begin
      stateD     = stateQ;
      pcD        = pcQ;
      flushCntD  = flushCntQ;
      misalignD  = 1'b0;
      takenCntD  = takenCntQ;
      branchCntD = branchCntQ;

      unique case (stateQ)
         StRun: begin
            if (redirect) begin
               if (target[1:0] == 2'b00) begin
                  pcD       = target;
                  stateD    = StFlush;
                  flushCntD = FlushCycles;
               end else begin
                  misalignD = 1'b1;
                  stateD    = StHalt;
               end
            end else if (!stall) begin
               pcD = pcQ + 32'd4;
            end
         end
         StFlush: begin
            if (!stall) begin
               pcD       = pcQ + 32'd4;
               flushCntD = flushCntQ - 2'd1;
               if (flushCntQ <= 2'd1) begin
                  stateD = StRun;
               end
            end
         end
         StHalt: begin
         end
         default: stateD = StRun;
      endcase

      if (accept && ex_is_branch && (branchCntQ != CntMax)) begin
         branchCntD = branchCntQ + CntOne;
      end
      if (accept && branchTaken && (takenCntQ != CntMax)) begin
         takenCntD = takenCntQ + CntOne;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stateQ     <= StRun;
         pcQ        <= RESET_PC;
         flushCntQ  <= 2'd0;
         misalignQ  <= 1'b0;
         takenCntQ  <= '0;
         branchCntQ <= '0;
      end else begin
         stateQ     <= stateD;
         pcQ        <= pcD;
         flushCntQ  <= flushCntD;
         misalignQ  <= misalignD;
         takenCntQ  <= takenCntD;
         branchCntQ <= branchCntD;
      end
   end

   assign pc           = pcQ;
   assign flush        = (stateQ != StRun);
   assign halted       = (stateQ == StHalt);
   assign misalign_err = misalignQ;
   assign taken_cnt    = takenCntQ;
   assign branch_cnt   = branchCntQ;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit (default and 4-bit counters).
module tb_pc_branch_unit;

   logic        clock;
   logic        reset;
   logic        ex_valid, stall;
   logic        ex_is_branch, ex_is_jal, ex_is_jalr;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_pc, ex_imm, ex_rs1;
   logic        BrEq, BrLT;

   logic        BrUn, flush, halted, misalign_err;
   logic [31:0] pc;
   logic [15:0] taken_cnt, branch_cnt;

   logic        brUn4, flush4, halted4, misalign4;
   logic [31:0] pc4;
   logic [3:0]  taken4, branch4;

   int errors = 0;
   int checks = 0;

   pc_branch_unit u_dut (
      .clock(clock), .reset(reset), .ex_valid(ex_valid), .stall(stall),
      .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
      .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
      .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn), .pc(pc), .flush(flush), .halted(halted),
      .misalign_err(misalign_err), .taken_cnt(taken_cnt), .branch_cnt(branch_cnt)
   );

   pc_branch_unit #(.CNT_W(4)) u_dut4 (
      .clock(clock), .reset(reset), .ex_valid(ex_valid), .stall(stall),
      .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
      .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
      .BrEq(BrEq), .BrLT(BrLT), .BrUn(brUn4), .pc(pc4), .flush(flush4), .halted(halted4),
      .misalign_err(misalign4), .taken_cnt(taken4), .branch_cnt(branch4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clearEx();
      ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
      ex_funct3 = 3'b000; ex_pc = 0; ex_imm = 0; ex_rs1 = 0; BrEq = 0; BrLT = 0;
   endtask

   task automatic test_reset();
      reset = 1; stall = 0; clearEx();
      step();
      reset = 0;
      checks++; if (pc !== 32'h0100_0000) begin errors++;
         $display("FAIL reset_pc got %h want 01000000", pc); end
      checks++; if ({flush, halted, misalign_err} !== 3'b000) begin errors++;
         $display("FAIL reset_flags got %b want 000", {flush, halted, misalign_err}); end
      checks++; if (taken_cnt !== 16'd0 || branch_cnt !== 16'd0) begin errors++;
         $display("FAIL reset_cnt got %0d/%0d want 0/0", taken_cnt, branch_cnt); end
      step();
      checks++; if (pc !== 32'h0100_0004 || flush !== 1'b0) begin errors++;
         $display("FAIL seq_pc1 got %h/%b want 01000004/0", pc, flush); end
      step();
      checks++; if (pc !== 32'h0100_0008 || flush !== 1'b0) begin errors++;
         $display("FAIL seq_pc2 got %h/%b want 01000008/0", pc, flush); end
   endtask

   task automatic test_beq_taken();
      step(); step();
      checks++; if (pc !== 32'h0100_0010) begin errors++;
         $display("FAIL beq_pre_pc got %h want 01000010", pc); end
      ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b000;
      ex_pc = 32'h0100_0008; ex_imm = 32'h20; BrEq = 1;
      step();
      checks++; if (pc !== 32'h0100_0028 || flush !== 1'b1) begin errors++;
         $display("FAIL beq_redirect got %h/%b want 01000028/1", pc, flush); end
      checks++; if (taken_cnt !== 16'd1 || branch_cnt !== 16'd1) begin errors++;
         $display("FAIL beq_cnt got %0d/%0d want 1/1", taken_cnt, branch_cnt); end
      // Younger op in the shadow: a JAL that must be ignored.
      clearEx(); ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h0000_2000;
      step();
      checks++; if (pc !== 32'h0100_002C || flush !== 1'b1) begin errors++;
         $display("FAIL flush1 got %h/%b want 0100002c/1", pc, flush); end
      step();
      checks++; if (pc !== 32'h0100_0030 || flush !== 1'b0) begin errors++;
         $display("FAIL flush2 got %h/%b want 01000030/0", pc, flush); end
      clearEx();
      checks++; if (taken4 !== 4'd1 || branch4 !== 4'd1) begin errors++;
         $display("FAIL beq_cnt4 got %0d/%0d want 1/1", taken4, branch4); end
   endtask

   task automatic test_bgeu_not_taken();
      ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b100; BrLT = 1;
      #1;
      checks++; if (BrUn !== 1'b0) begin errors++;
         $display("FAIL brun_blt got %b want 0", BrUn); end
      ex_funct3 = 3'b111; ex_pc = 32'h0100_0020; ex_imm = 32'h40;
      #1;
      checks++; if (BrUn !== 1'b1) begin errors++;
         $display("FAIL brun_bgeu got %b want 1", BrUn); end
      step();
      checks++; if (pc !== 32'h0100_0034 || flush !== 1'b0) begin errors++;
         $display("FAIL bgeu_pc got %h/%b want 01000034/0", pc, flush); end
      checks++; if (taken_cnt !== 16'd1 || branch_cnt !== 16'd2) begin errors++;
         $display("FAIL bgeu_cnt got %0d/%0d want 1/2", taken_cnt, branch_cnt); end
      clearEx();
   endtask

   task automatic test_stall_bne();
      ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b001; BrEq = 0;
      ex_pc = 32'h0100_0034; ex_imm = 32'h100; stall = 1;
      step();
      checks++; if (pc !== 32'h0100_0134 || flush !== 1'b1) begin errors++;
         $display("FAIL bne_stall_redirect got %h/%b want 01000134/1", pc, flush); end
      checks++; if (taken_cnt !== 16'd2 || branch_cnt !== 16'd3) begin errors++;
         $display("FAIL bne_cnt got %0d/%0d want 2/3", taken_cnt, branch_cnt); end
      clearEx();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (pc !== 32'h0100_0134 || flush !== 1'b1) begin errors++;
            $display("FAIL stall_hold%0d got %h/%b want 01000134/1", i, pc, flush); end
      end
      stall = 0;
      step();
      checks++; if (pc !== 32'h0100_0138 || flush !== 1'b1) begin errors++;
         $display("FAIL unstall1 got %h/%b want 01000138/1", pc, flush); end
      step();
      checks++; if (pc !== 32'h0100_013C || flush !== 1'b0) begin errors++;
         $display("FAIL unstall2 got %h/%b want 0100013c/0", pc, flush); end
   endtask

   task automatic test_saturate();
      reset = 1; step(); reset = 0;
      for (int i = 0; i < 17; i++) begin
         ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b000; BrEq = 1;
         ex_pc = 32'h0100_0000; ex_imm = 32'h40;
         step();
         clearEx();
         step(); step();
      end
      checks++; if (taken4 !== 4'hF || branch4 !== 4'hF) begin errors++;
         $display("FAIL sat4 got %h/%h want f/f", taken4, branch4); end
      checks++; if (taken_cnt !== 16'd17 || branch_cnt !== 16'd17) begin errors++;
         $display("FAIL cnt16 got %0d/%0d want 17/17", taken_cnt, branch_cnt); end
   endtask

   task automatic test_reset_override();
      reset = 1; ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h0100_0000; ex_imm = 32'h100;
      step();
      reset = 0; clearEx();
      checks++; if (pc !== 32'h0100_0000 || flush !== 1'b0) begin errors++;
         $display("FAIL rst_jal got %h/%b want 01000000/0", pc, flush); end
      checks++; if (taken4 !== 4'd0 || branch_cnt !== 16'd0) begin errors++;
         $display("FAIL rst_cnt got %0d/%0d want 0/0", taken4, branch_cnt); end
   endtask

   task automatic test_jalr_misalign();
      ex_valid = 1; ex_is_jalr = 1; ex_rs1 = 32'h0100_0103; ex_imm = 0;
      step();
      clearEx();
      checks++; if ({misalign_err, halted, flush} !== 3'b111) begin errors++;
         $display("FAIL jalr_err got %b want 111", {misalign_err, halted, flush}); end
      checks++; if (pc !== 32'h0100_0004) begin errors++;
         $display("FAIL jalr_pc got %h want 01000004", pc); end
      step();
      checks++; if ({misalign_err, halted} !== 2'b01 || pc !== 32'h0100_0004) begin errors++;
         $display("FAIL halt_hold got %b/%h want 01/01000004", {misalign_err, halted}, pc); end
      ex_valid = 1; ex_is_branch = 1; BrEq = 1; ex_pc = 32'h0100_0000; ex_imm = 32'h10;
      step(); step();
      clearEx();
      checks++; if (pc !== 32'h0100_0004 || branch_cnt !== 16'd0 || halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_ignore got %h/%0d/%b want 01000004/0/1", pc, branch_cnt, halted);
      end
      reset = 1; step(); reset = 0;
      checks++; if (halted !== 1'b0 || pc !== 32'h0100_0000) begin errors++;
         $display("FAIL halt_reset got %b/%h want 0/01000000", halted, pc); end
   endtask

   initial begin
      test_reset();
      test_beq_taken();
      test_bgeu_not_taken();
      test_stall_bne();
      test_saturate();
      test_reset_override();
      // One fetch advance after reset so the frozen PC is distinguishable.
      step();
      test_jalr_misalign();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
